hex_print_ctrl: RTL and testbench



---
 rtl/hex_print_ctrl_if.sv | 30 +++
 rtl/hex_print_ctrl.sv | 114 +++++++++++
 tb/tb_hex_print_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hex_print_ctrl_if.sv
// Request and byte-stream handshake bundle for hex_print_ctrl.
// slave is the sequencer; master is the requester plus the UART TX consumer.
interface hex_print_ctrl_if #(
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned MAX_DIG = DATA_W / 4;
    localparam int unsigned DIG_W   = $clog2(MAX_DIG) + 1;

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_data;
    logic [DIG_W-1:0]  req_digits;
    logic              req_term_en;
    logic [7:0]        req_term;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        tx_data;
    logic              busy;
    logic              done;

    modport slave (
        input  req_valid, req_data, req_digits, req_term_en, req_term, tx_ready,
        output req_ready, tx_valid, tx_data, busy, done
    );

    modport master (
        output req_valid, req_data, req_digits, req_term_en, req_term, tx_ready,
        input  req_ready, tx_valid, tx_data, busy, done
    );
endinterface

// File: rtl/hex_print_ctrl.sv
// Hex-to-ASCII print sequencer: walks a value MS nibble first and emits one
// uppercase ASCII byte per tx handshake, optionally followed by a terminator.
module hex_print_ctrl #(
    parameter int unsigned DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    hex_print_ctrl_if.slave bus
);
    localparam int unsigned MAX_DIG = DATA_W / 4;
    localparam int unsigned DIG_W   = $clog2(MAX_DIG) + 1;
    localparam logic [DIG_W-1:0] MaxDig = DIG_W'(MAX_DIG);
    localparam logic [DIG_W-1:0] One    = DIG_W'(1);

    typedef enum logic [1:0] {StIdle, StDigit, StTerm} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] sh_q;
    logic [DIG_W-1:0]  cnt_q;
    logic              term_en_q;
    logic [7:0]        term_q;
    logic              tx_valid_q;
    logic [7:0]        tx_data_q;
    logic              done_q;

    logic [DIG_W-1:0]  n_clamp;
    logic [DIG_W+1:0]  shamt;
    logic [DATA_W-1:0] sh_load;
    logic [DATA_W-1:0] sh_next;
    logic              hs;

    function automatic logic [7:0] to_ascii(input logic [3:0] nib);
        // 'A' - 10 = 0x37
        if (nib >= 4'd10) begin
            return {4'h0, nib} + 8'h37;
        end
        return {4'h0, nib} + 8'h30;
    endfunction

    // Clamp the digit count and left-align the requested digits at the top.
    always_comb begin
        n_clamp = bus.req_digits;
        if (bus.req_digits == '0 || bus.req_digits > MaxDig) begin
            n_clamp = MaxDig;
        end
        shamt   = {2'b00, MaxDig - n_clamp} << 2;
        sh_load = bus.req_data << shamt;
        sh_next = sh_q << 4;
        hs      = tx_valid_q && bus.tx_ready;
    end

    // Sequencer FSM with registered tx_valid, tx_data and done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            sh_q       <= '0;
            cnt_q      <= '0;
            term_en_q  <= 1'b0;
            term_q     <= 8'h00;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        sh_q       <= sh_load;
                        cnt_q      <= n_clamp;
                        term_en_q  <= bus.req_term_en;
                        term_q     <= bus.req_term;
                        tx_data_q  <= to_ascii(sh_load[DATA_W-1 -: 4]);
                        tx_valid_q <= 1'b1;
                        state_q    <= StDigit;
                    end
                end
                StDigit: begin
                    if (hs) begin
                        sh_q  <= sh_next;
                        cnt_q <= cnt_q - One;
                        if (cnt_q > One) begin
                            tx_data_q <= to_ascii(sh_next[DATA_W-1 -: 4]);
                        end else if (term_en_q) begin
                            tx_data_q <= term_q;
                            state_q   <= StTerm;
                        end else begin
                            tx_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= StIdle;
                        end
                    end
                end
                StTerm: begin
                    if (hs) begin
                        tx_valid_q <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: begin
                    state_q    <= StIdle;
                    tx_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Ready/busy follow the state directly so an async reset drops busy at once.
    assign bus.req_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_hex_print_ctrl.sv
// Self-checking bench for hex_print_ctrl: a string-level model predicts the
// byte stream, ready/busy and done each cycle; literal tables pin the model.
module tb_hex_print_ctrl;
    logic clk;
    logic rst;

    hex_print_ctrl_if #(.DATA_W(32)) bus ();

    hex_print_ctrl #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model state
    logic [7:0] q[$];
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    int         acc_cyc = 0;

    // observed stream
    logic [7:0] rx[$];
    int         tx_cycs[$];
    int         done_cycs[$];
    int         done_cnt = 0;
    logic [7:0] exp_lit[$];

    int rdy_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_string(input logic [31:0] data, input int digits,
                                        input bit te, input logic [7:0] term);
        int n;
        int nib;
        n = (digits == 0 || digits > 8) ? 8 : digits;
        for (int i = n - 1; i >= 0; i--) begin
            nib = int'((data >> (4 * i)) & 32'hF);
            if (nib < 10) q.push_back(8'(8'h30 + nib));
            else          q.push_back(8'(8'h41 + nib - 10));
        end
        if (te) q.push_back(term);
    endfunction

    function automatic void model_reset();
        q.delete();
        m_busy = 1'b0;
        m_done = 1'b0;
    endfunction

    // Per-cycle compare and model advance, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                chk("req_ready", 32'(bus.req_ready), 32'(!m_busy));
                chk("busy", 32'(bus.busy), 32'(m_busy));
                chk("tx_valid", 32'(bus.tx_valid), 32'(m_busy));
                chk("done", 32'(bus.done), 32'(m_done));
                if (m_busy && q.size() > 0) chk("tx_data", 32'(bus.tx_data), 32'(q[0]));
                if (bus.tx_valid && bus.tx_ready) begin
                    rx.push_back(bus.tx_data);
                    tx_cycs.push_back(cyc);
                end
                if (bus.done) begin
                    done_cnt++;
                    done_cycs.push_back(cyc);
                end
                m_done = 1'b0;
                if (!m_busy) begin
                    if (bus.req_valid) begin
                        push_string(bus.req_data, int'(bus.req_digits), bus.req_term_en,
                                    bus.req_term);
                        m_busy  = 1'b1;
                        acc_cyc = cyc;
                    end
                end else if (bus.tx_ready) begin
                    void'(q.pop_front());
                    if (q.size() == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end
                end
            end
        end
    end

    // Consumer ready: always high, or the 1,0,0 repeating pattern.
    initial begin
        int k;
        k = 0;
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_ready = (rdy_mode == 1) ? (k % 3 == 0) : 1'b1;
            k++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        rx.delete();
        tx_cycs.delete();
        done_cycs.delete();
    endtask

    task automatic send_req(input logic [31:0] data, input logic [3:0] digits, input bit te,
                            input logic [7:0] term, input bit hold);
        bit acc;
        int tries;
        @(posedge clk);
        #1;
        bus.req_data    = data;
        bus.req_digits  = digits;
        bus.req_term_en = te;
        bus.req_term    = term;
        bus.req_valid   = 1'b1;
        tries = 0;
        do begin
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk);
            tries++;
        end while (!acc && tries < 50);
        if (!acc) chk("req_accept_timeout", 32'd0, 32'd1);
        #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt > d0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_rx(input string name);
        chk({name, "_len"}, 32'(rx.size()), 32'(exp_lit.size()));
        for (int i = 0; i < exp_lit.size(); i++) begin
            if (i < rx.size()) chk({name, "_byte"}, 32'(rx[i]), 32'(exp_lit[i]));
        end
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_data    = '0;
        bus.req_digits  = '0;
        bus.req_term_en = 1'b0;
        bus.req_term    = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'h00);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);

        // 8 digits, no terminator, ready held high
        clear_obs();
        send_req(32'h1234ABCD, 4'd8, 1'b0, 8'h00, 1'b0);
        wait_done(100);
        exp_lit = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44};
        check_rx("t1");
        if (tx_cycs.size() > 0) chk("t1_first_lat", 32'(tx_cycs[0] - acc_cyc), 32'd1);
        if (tx_cycs.size() == 8) chk("t1_consecutive", 32'(tx_cycs[7] - tx_cycs[0]), 32'd7);
        if (done_cycs.size() > 0 && tx_cycs.size() > 0)
            chk("t1_done_lat", 32'(done_cycs[0] - tx_cycs[0]), 32'd8);

        // 2 digits with newline terminator
        clear_obs();
        send_req(32'h000000FE, 4'd2, 1'b1, 8'h0A, 1'b0);
        wait_done(100);
        exp_lit = '{8'h46, 8'h45, 8'h0A};
        check_rx("t2");
        if (done_cycs.size() > 0 && tx_cycs.size() > 0)
            chk("t2_done_lat", 32'(done_cycs[0] - tx_cycs[0]), 32'd3);

        // same as first case with a stalling consumer
        clear_obs();
        rdy_mode = 1;
        send_req(32'h1234ABCD, 4'd8, 1'b0, 8'h00, 1'b0);
        wait_done(200);
        rdy_mode = 0;
        exp_lit = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44};
        check_rx("t3");
        if (done_cycs.size() > 0 && tx_cycs.size() == 8)
            chk("t3_done_after_last", 32'(done_cycs[0] - tx_cycs[7]), 32'd1);

        // digit count 0 and 12 both clamp to 8
        exp_lit = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h46};
        clear_obs();
        send_req(32'h0000000F, 4'd0, 1'b0, 8'h00, 1'b0);
        wait_done(100);
        check_rx("t4_d0");
        clear_obs();
        send_req(32'h0000000F, 4'd12, 1'b0, 8'h00, 1'b0);
        wait_done(100);
        check_rx("t4_d12");

        // async reset after three bytes
        clear_obs();
        send_req(32'h1234ABCD, 4'd8, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 50 && rx.size() < 3; i++) @(posedge clk);
        #1;
        chk("t5_rx_before_rst", 32'(rx.size()), 32'd3);
        rst = 1'b1;
        model_reset();
        #1;
        chk("t5_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("t5_rst_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("t5_req_ready", 32'(bus.req_ready), 32'd1);
        chk("t5_no_more_bytes", 32'(rx.size()), 32'd3);

        // req_valid held high with changed data; second accepted in done cycle
        clear_obs();
        send_req(32'h1234ABCD, 4'd8, 1'b0, 8'h00, 1'b1);
        bus.req_data    = 32'hDEADBEEF;
        bus.req_digits  = 4'd4;
        bus.req_term_en = 1'b1;
        bus.req_term    = 8'h20;
        wait_done(100);
        #1;
        bus.req_valid = 1'b0;
        wait_done(100);
        exp_lit = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44,
                    8'h42, 8'h45, 8'h45, 8'h46, 8'h20};
        check_rx("t6");
        if (done_cycs.size() > 0 && tx_cycs.size() > 8)
            chk("t6_gap", 32'(tx_cycs[8] - done_cycs[0]), 32'd1);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
